// File: rtl/alu_reservation_station_pkg.sv
// alu_reservation_station_pkg
//   Shared sizing constants and ALU opcode encodings for the ALU
//   reservation station slice. No ports; imported by the station and
//   by its bench.
package alu_reservation_station_pkg;

  localparam int ARS_ENTRY_NUM     = 8;
  localparam int ARS_ENTRY_SEL_LEN = 3;
  localparam int ARS_RRF_TAG_LEN   = 6;
  localparam int ARS_DATA_LEN      = 32;
  localparam int ARS_ALU_OP_WIDTH  = 4;

  // Opcode encodings understood by the ALU execute stage. The station
  // never decodes them; it only carries the field through.
  typedef enum logic [ARS_ALU_OP_WIDTH-1:0] {
    ALU_OP_ADD = 4'd0,
    ALU_OP_SUB = 4'd1,
    ALU_OP_AND = 4'd2,
    ALU_OP_OR  = 4'd3,
    ALU_OP_XOR = 4'd4,
    ALU_OP_SLL = 4'd5,
    ALU_OP_SRL = 4'd6,
    ALU_OP_SRA = 4'd7
  } alu_op_e;

endpackage

// File: rtl/alu_reservation_station_prio_enc.sv
// prio_enc_lsb
//   Lowest-index-first priority encoder.
//   Ports:
//     req_i   [WIDTH-1:0]    request vector
//     idx_o   [SEL_LEN-1:0]  index of the lowest set request bit (0 if none)
//     found_o                at least one request bit is set
module prio_enc_lsb #(
  parameter int WIDTH   = 8,
  parameter int SEL_LEN = 3
) (
  input  logic [WIDTH-1:0]   req_i,
  output logic [SEL_LEN-1:0] idx_o,
  output logic               found_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = '0;
    found_o = |req_i;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = SEL_LEN'(i);
      end
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// alu_reservation_station
//   Holds dispatched ALU ops until both operands are available, then
//   issues at most one op per cycle to the ALU execute stage. Waiting
//   operands are woken by snooping the execute stage's registered
//   writeback bus.
//   Ports:
//     clk_i, reset_i (sync, active high), kill_i (flush all entries)
//     dispatch_i, disp_alu_op_i, disp_src1_i/disp_valid1_i,
//     disp_src2_i/disp_valid2_i, disp_rrf_tag_i, disp_wrrf_i : new op
//     full_o : no free entry, dispatch ignored
//     fwd_we_i, fwd_tag_i, fwd_data_i : execute-stage writeback snoop
//     issue_o, alu_op_o, src1_o, src2_o, rrf_tag_o, if_write_rrf_o :
//       registered issue to the execute stage
module alu_reservation_station
  import alu_reservation_station_pkg::*;
#(
  parameter int ENTRY_NUM     = ARS_ENTRY_NUM,
  parameter int ENTRY_SEL_LEN = ARS_ENTRY_SEL_LEN,
  parameter int RRF_TAG_LEN   = ARS_RRF_TAG_LEN,
  parameter int DATA_LEN      = ARS_DATA_LEN,
  parameter int ALU_OP_WIDTH  = ARS_ALU_OP_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    kill_i,
  input  logic                    dispatch_i,
  input  logic [ALU_OP_WIDTH-1:0] disp_alu_op_i,
  input  logic [DATA_LEN-1:0]     disp_src1_i,
  input  logic                    disp_valid1_i,
  input  logic [DATA_LEN-1:0]     disp_src2_i,
  input  logic                    disp_valid2_i,
  input  logic [RRF_TAG_LEN-1:0]  disp_rrf_tag_i,
  input  logic                    disp_wrrf_i,
  output logic                    full_o,
  input  logic                    fwd_we_i,
  input  logic [RRF_TAG_LEN-1:0]  fwd_tag_i,
  input  logic [DATA_LEN-1:0]     fwd_data_i,
  output logic                    issue_o,
  output logic [ALU_OP_WIDTH-1:0] alu_op_o,
  output logic [DATA_LEN-1:0]     src1_o,
  output logic [DATA_LEN-1:0]     src2_o,
  output logic [RRF_TAG_LEN-1:0]  rrf_tag_o,
  output logic                    if_write_rrf_o
);

  // Per-field entry storage
  logic [ENTRY_NUM-1:0]    valid_q, valid_d;
  logic [ENTRY_NUM-1:0]    v1_q, v1_d;
  logic [ENTRY_NUM-1:0]    v2_q, v2_d;
  logic [ENTRY_NUM-1:0]    wrrf_q, wrrf_d;
  logic [ALU_OP_WIDTH-1:0] op_q   [ENTRY_NUM];
  logic [ALU_OP_WIDTH-1:0] op_d   [ENTRY_NUM];
  logic [DATA_LEN-1:0]     src1_q [ENTRY_NUM];
  logic [DATA_LEN-1:0]     src1_d [ENTRY_NUM];
  logic [DATA_LEN-1:0]     src2_q [ENTRY_NUM];
  logic [DATA_LEN-1:0]     src2_d [ENTRY_NUM];
  logic [RRF_TAG_LEN-1:0]  tag_q  [ENTRY_NUM];
  logic [RRF_TAG_LEN-1:0]  tag_d  [ENTRY_NUM];

  // Issue output registers
  logic                    issue_q, issue_d;
  logic [ALU_OP_WIDTH-1:0] out_op_q, out_op_d;
  logic [DATA_LEN-1:0]     out_src1_q, out_src1_d;
  logic [DATA_LEN-1:0]     out_src2_q, out_src2_d;
  logic [RRF_TAG_LEN-1:0]  out_tag_q, out_tag_d;
  logic                    out_wrrf_q, out_wrrf_d;

  logic [ENTRY_NUM-1:0]     wake1, wake2, ready;
  logic [ENTRY_SEL_LEN-1:0] free_idx, sel_idx;
  logic                     free_found, sel_found;
  logic                     disp_fire;
  logic                     disp_byp1, disp_byp2;

  assign full_o    = &valid_q;
  assign disp_fire = dispatch_i & ~full_o;

  // An operand still waiting holds its producer's tag in its low bits.
  genvar gi;
  generate
    for (gi = 0; gi < ENTRY_NUM; gi++) begin : g_entry
      assign wake1[gi] = valid_q[gi] & ~v1_q[gi] & fwd_we_i &
                         (fwd_tag_i == src1_q[gi][RRF_TAG_LEN-1:0]);
      assign wake2[gi] = valid_q[gi] & ~v2_q[gi] & fwd_we_i &
                         (fwd_tag_i == src2_q[gi][RRF_TAG_LEN-1:0]);
      assign ready[gi] = valid_q[gi] & v1_q[gi] & v2_q[gi];
    end
  endgenerate

  // The producer may be writing back in the very cycle its consumer dispatches.
  assign disp_byp1 = ~disp_valid1_i & fwd_we_i &
                     (fwd_tag_i == disp_src1_i[RRF_TAG_LEN-1:0]);
  assign disp_byp2 = ~disp_valid2_i & fwd_we_i &
                     (fwd_tag_i == disp_src2_i[RRF_TAG_LEN-1:0]);

  prio_enc_lsb #(
    .WIDTH   (ENTRY_NUM),
    .SEL_LEN (ENTRY_SEL_LEN)
  ) u_free_enc (
    .req_i   (~valid_q),
    .idx_o   (free_idx),
    .found_o (free_found)
  );

  prio_enc_lsb #(
    .WIDTH   (ENTRY_NUM),
    .SEL_LEN (ENTRY_SEL_LEN)
  ) u_sel_enc (
    .req_i   (ready),
    .idx_o   (sel_idx),
    .found_o (sel_found)
  );

  // Entry next state. The selected entry is already fully ready, so it can
  // never be the target of a wakeup, and the dispatch slot is free, so it
  // can never be the selected one.
  always_comb begin
    valid_d = valid_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    wrrf_d  = wrrf_q;
    op_d    = op_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    tag_d   = tag_q;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (wake1[i]) begin
        src1_d[i] = fwd_data_i;
        v1_d[i]   = 1'b1;
      end
      if (wake2[i]) begin
        src2_d[i] = fwd_data_i;
        v2_d[i]   = 1'b1;
      end
      if (sel_found && (sel_idx == ENTRY_SEL_LEN'(i))) begin
        valid_d[i] = 1'b0;
      end
      if (disp_fire && free_found && (free_idx == ENTRY_SEL_LEN'(i))) begin
        valid_d[i] = 1'b1;
        op_d[i]    = disp_alu_op_i;
        src1_d[i]  = disp_byp1 ? fwd_data_i : disp_src1_i;
        v1_d[i]    = disp_valid1_i | disp_byp1;
        src2_d[i]  = disp_byp2 ? fwd_data_i : disp_src2_i;
        v2_d[i]    = disp_valid2_i | disp_byp2;
        tag_d[i]   = disp_rrf_tag_i;
        wrrf_d[i]  = disp_wrrf_i;
      end
    end
    // Flush wins over everything else, including the dispatch above.
    if (kill_i) begin
      valid_d = '0;
    end
  end

  // Issue registers; data fields hold their last value when nothing issues.
  always_comb begin
    issue_d    = sel_found & ~kill_i;
    out_op_d   = out_op_q;
    out_src1_d = out_src1_q;
    out_src2_d = out_src2_q;
    out_tag_d  = out_tag_q;
    out_wrrf_d = out_wrrf_q;
    if (issue_d) begin
      out_op_d   = op_q[sel_idx];
      out_src1_d = src1_q[sel_idx];
      out_src2_d = src2_q[sel_idx];
      out_tag_d  = tag_q[sel_idx];
      out_wrrf_d = wrrf_q[sel_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q    <= '0;
      issue_q    <= 1'b0;
      out_op_q   <= '0;
      out_src1_q <= '0;
      out_src2_q <= '0;
      out_tag_q  <= '0;
      out_wrrf_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      issue_q    <= issue_d;
      out_op_q   <= out_op_d;
      out_src1_q <= out_src1_d;
      out_src2_q <= out_src2_d;
      out_tag_q  <= out_tag_d;
      out_wrrf_q <= out_wrrf_d;
    end
  end

  // Payload fields are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk_i) begin
    v1_q   <= v1_d;
    v2_q   <= v2_d;
    wrrf_q <= wrrf_d;
    op_q   <= op_d;
    src1_q <= src1_d;
    src2_q <= src2_d;
    tag_q  <= tag_d;
  end

  assign issue_o        = issue_q;
  assign alu_op_o       = out_op_q;
  assign src1_o         = out_src1_q;
  assign src2_o         = out_src2_q;
  assign rrf_tag_o      = out_tag_q;
  assign if_write_rrf_o = out_wrrf_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// tb_alu_reservation_station
//   Directed scenarios for the ALU reservation station. Expected issues
//   are queued by the stimulus; a negedge monitor pops and compares
//   every issue the station presents.
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        kill_i = 1'b0;
  logic        dispatch_i = 1'b0;
  logic [3:0]  disp_alu_op_i = '0;
  logic [31:0] disp_src1_i = '0;
  logic        disp_valid1_i = 1'b0;
  logic [31:0] disp_src2_i = '0;
  logic        disp_valid2_i = 1'b0;
  logic [5:0]  disp_rrf_tag_i = '0;
  logic        disp_wrrf_i = 1'b0;
  logic        full_o;
  logic        fwd_we_i = 1'b0;
  logic [5:0]  fwd_tag_i = '0;
  logic [31:0] fwd_data_i = '0;
  logic        issue_o;
  logic [3:0]  alu_op_o;
  logic [31:0] src1_o;
  logic [31:0] src2_o;
  logic [5:0]  rrf_tag_o;
  logic        if_write_rrf_o;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [5:0]  tag;
    logic        wrrf;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_got, mon_exp;
  int   total = 0;
  int   bad = 0;

  alu_reservation_station dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .kill_i         (kill_i),
    .dispatch_i     (dispatch_i),
    .disp_alu_op_i  (disp_alu_op_i),
    .disp_src1_i    (disp_src1_i),
    .disp_valid1_i  (disp_valid1_i),
    .disp_src2_i    (disp_src2_i),
    .disp_valid2_i  (disp_valid2_i),
    .disp_rrf_tag_i (disp_rrf_tag_i),
    .disp_wrrf_i    (disp_wrrf_i),
    .full_o         (full_o),
    .fwd_we_i       (fwd_we_i),
    .fwd_tag_i      (fwd_tag_i),
    .fwd_data_i     (fwd_data_i),
    .issue_o        (issue_o),
    .alu_op_o       (alu_op_o),
    .src1_o         (src1_o),
    .src2_o         (src2_o),
    .rrf_tag_o      (rrf_tag_o),
    .if_write_rrf_o (if_write_rrf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock edge; returns at the following negedge where outputs are stable.
  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic set_disp(input logic [3:0] op, input logic [31:0] s1, input logic v1,
                          input logic [31:0] s2, input logic v2,
                          input logic [5:0] tag, input logic wrrf);
    dispatch_i     = 1'b1;
    disp_alu_op_i  = op;
    disp_src1_i    = s1;
    disp_valid1_i  = v1;
    disp_src2_i    = s2;
    disp_valid2_i  = v2;
    disp_rrf_tag_i = tag;
    disp_wrrf_i    = wrrf;
  endtask

  task automatic set_fwd(input logic [5:0] tag, input logic [31:0] data);
    fwd_we_i   = 1'b1;
    fwd_tag_i  = tag;
    fwd_data_i = data;
  endtask

  task automatic clr();
    dispatch_i = 1'b0;
    fwd_we_i   = 1'b0;
    kill_i     = 1'b0;
  endtask

  task automatic push(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2,
                      input logic [5:0] tag, input logic wrrf);
    exp_t e;
    e.op   = op;
    e.s1   = s1;
    e.s2   = s2;
    e.tag  = tag;
    e.wrrf = wrrf;
    sb_q.push_back(e);
  endtask

  // Scoreboard monitor
  always @(negedge clk_i) begin
    if (reset_i === 1'b0 && issue_o === 1'b1) begin
      mon_got = {alu_op_o, src1_o, src2_o, rrf_tag_o, if_write_rrf_o};
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL issue_unexpected: got op=%0h s1=%0h s2=%0h tag=%0h wrrf=%0b expected no issue",
                 mon_got.op, mon_got.s1, mon_got.s2, mon_got.tag, mon_got.wrrf);
      end else begin
        mon_exp = sb_q.pop_front();
        if (mon_got !== mon_exp) begin
          bad++;
          $display("FAIL issue_data: got op=%0h s1=%0h s2=%0h tag=%0h wrrf=%0b expected op=%0h s1=%0h s2=%0h tag=%0h wrrf=%0b",
                   mon_got.op, mon_got.s1, mon_got.s2, mon_got.tag, mon_got.wrrf,
                   mon_exp.op, mon_exp.s1, mon_exp.s2, mon_exp.tag, mon_exp.wrrf);
        end else begin
          $display("issue op=%0h s1=%0h s2=%0h tag=%0h wrrf=%0b ok",
                   mon_got.op, mon_got.s1, mon_got.s2, mon_got.tag, mon_got.wrrf);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle
    repeat (3) cyc();
    chk("reset_issue", {31'd0, issue_o}, 32'd0);
    chk("reset_full", {31'd0, full_o}, 32'd0);
    chk("reset_data", src1_o | src2_o | {28'd0, alu_op_o} | {26'd0, rrf_tag_o} | {31'd0, if_write_rrf_o}, 32'd0);
    reset_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_full", {31'd0, full_o}, 32'd0);
      chk("idle_issue", {31'd0, issue_o}, 32'd0);
    end

    // Ready op: written at one edge, issued at the next
    set_disp(ALU_OP_ADD, 32'd5, 1'b1, 32'd7, 1'b1, 6'd3, 1'b1);
    push(ALU_OP_ADD, 32'd5, 32'd7, 6'd3, 1'b1);
    cyc(); clr();
    chk("ready_lat0", {31'd0, issue_o}, 32'd0);
    cyc();
    chk("ready_lat1", {31'd0, issue_o}, 32'd1);
    cyc();
    chk("ready_after", {31'd0, issue_o}, 32'd0);

    // Wakeup of src2 (tag 9); wrong tag 8 must not wake it
    set_disp(ALU_OP_SUB, 32'h10, 1'b1, 32'd9, 1'b0, 6'd10, 1'b1);
    cyc(); clr();
    chk("wait_noissue0", {31'd0, issue_o}, 32'd0);
    set_fwd(6'd8, 32'h5555);
    cyc(); clr();
    chk("wait_noissue1", {31'd0, issue_o}, 32'd0);
    cyc();
    chk("wrong_tag_noissue", {31'd0, issue_o}, 32'd0);
    set_fwd(6'd9, 32'h1234);
    push(ALU_OP_SUB, 32'h10, 32'h1234, 6'd10, 1'b1);
    cyc(); clr();
    chk("wake_lat0", {31'd0, issue_o}, 32'd0);
    cyc();
    chk("wake_issue", {31'd0, issue_o}, 32'd1);
    cyc();

    // Same-cycle dispatch bypass on src1
    set_disp(ALU_OP_AND, 32'd4, 1'b0, 32'h77, 1'b1, 6'd5, 1'b0);
    set_fwd(6'd4, 32'hAA);
    push(ALU_OP_AND, 32'hAA, 32'h77, 6'd5, 1'b0);
    cyc(); clr();
    chk("bypass_lat0", {31'd0, issue_o}, 32'd0);
    cyc();
    chk("bypass_issue", {31'd0, issue_o}, 32'd1);
    cyc();

    // Fill all 8 slots with waiting ops (src2 tag 0x20+i)
    for (int i = 0; i < 8; i++) begin
      set_disp(ALU_OP_OR, 32'h50 + i, 1'b1, 32'h20 + i, 1'b0, 6'(i), 1'b1);
      cyc();
      chk("fill_full", {31'd0, full_o}, (i == 7) ? 32'd1 : 32'd0);
    end
    // 9th dispatch (ready) while full: dropped
    set_disp(ALU_OP_XOR, 32'h99, 1'b1, 32'h98, 1'b1, 6'h3F, 1'b1);
    cyc(); clr();
    chk("drop_full", {31'd0, full_o}, 32'd1);
    chk("drop_issue0", {31'd0, issue_o}, 32'd0);
    cyc();
    chk("drop_issue1", {31'd0, issue_o}, 32'd0);
    // Wake slot 5
    set_fwd(6'h25, 32'hBEEF);
    push(ALU_OP_OR, 32'h55, 32'hBEEF, 6'd5, 1'b1);
    cyc(); clr();
    chk("wake5_lat0", {31'd0, issue_o}, 32'd0);
    chk("wake5_full", {31'd0, full_o}, 32'd1);
    cyc();
    chk("wake5_issue", {31'd0, issue_o}, 32'd1);
    chk("slot_freed", {31'd0, full_o}, 32'd0);
    // Retry the 9th op into the freed slot
    set_disp(ALU_OP_XOR, 32'h99, 1'b1, 32'h98, 1'b1, 6'h3F, 1'b1);
    push(ALU_OP_XOR, 32'h99, 32'h98, 6'h3F, 1'b1);
    cyc(); clr();
    chk("refill_full", {31'd0, full_o}, 32'd1);
    cyc();
    chk("refill_issue", {31'd0, issue_o}, 32'd1);
    chk("refill_freed", {31'd0, full_o}, 32'd0);
    cyc();
    chk("refill_after", {31'd0, issue_o}, 32'd0);
    kill_i = 1'b1;
    cyc(); clr();
    chk("flush_full", {31'd0, full_o}, 32'd0);
    chk("flush_issue", {31'd0, issue_o}, 32'd0);

    // Kill discards a same-cycle dispatch
    set_disp(ALU_OP_ADD, 32'd1, 1'b1, 32'd2, 1'b1, 6'd7, 1'b1);
    kill_i = 1'b1;
    cyc(); clr();
    chk("killdisp_full", {31'd0, full_o}, 32'd0);
    cyc();
    chk("killdisp_issue", {31'd0, issue_o}, 32'd0);

    // Slots 1,2,6 become ready together; kill right after the first issue
    for (int i = 0; i < 8; i++) begin
      set_disp(ALU_OP_SLL, 32'h100 + i, 1'b1,
               (i == 1 || i == 2 || i == 6) ? 32'h11 : 32'h22, 1'b0, 6'(i), 1'b1);
      cyc();
    end
    clr();
    chk("kill_setup_full", {31'd0, full_o}, 32'd1);
    set_fwd(6'h11, 32'hC0DE);
    cyc(); clr();
    chk("kill_wake_lat0", {31'd0, issue_o}, 32'd0);
    push(ALU_OP_SLL, 32'h101, 32'hC0DE, 6'd1, 1'b1);
    cyc();
    chk("kill_first_issue", {31'd0, issue_o}, 32'd1);
    kill_i = 1'b1;
    cyc(); clr();
    chk("kill_issue", {31'd0, issue_o}, 32'd0);
    chk("kill_full", {31'd0, full_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("kill_quiet", {31'd0, issue_o}, 32'd0);
    end

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
